mux_rr_arbiter: RTL and testbench



---
 rtl/mux_rr_arbiter_pkg.sv | 21 ++
 rtl/rr_pick.sv | 27 ++
 rtl/mux_rr_arbiter.sv | 95 +++++++++
 tb/tb_mux_rr_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants and types for the round-robin mux arbiter.
// Requester count, select width and controller state encodings.
package mux_rr_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    function automatic logic [SEL_W-1:0] next_idx(
        input logic [SEL_W-1:0] i
    );
        return i + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search: first set request at or after Ptr,
// wrapping from the top index back to zero.
module rr_pick
    import mux_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] Req,
    input  logic [SEL_W-1:0] Ptr,
    output logic             Any,
    output logic [SEL_W-1:0] Win
);

    logic [SEL_W-1:0] idx;

    // Walk offsets from far to near so the nearest hit wins last.
    always_comb begin
        Any = |Req;
        Win = Ptr;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = Ptr + SEL_W'(k);
            if (Req[idx]) begin
                Win = idx;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the shared 8:1 mux select lines,
// with bounded bursts and a turnaround cycle between owners.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [N_REQ-1:0] Req,
    output logic [N_REQ-1:0] Grant,
    output logic [SEL_W-1:0] Select,
    output logic             Valid,
    output logic             Busy
);

    arb_state_t       state, state_n;
    logic [SEL_W-1:0] ptr, ptr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [N_REQ-1:0] grant_n;
    logic [SEL_W-1:0] sel_n;
    logic             valid_n;
    logic             busy_n;
    logic             any;
    logic [SEL_W-1:0] win;

    rr_pick u_pick (
        .Req (Req),
        .Ptr (ptr),
        .Any (any),
        .Win (win)
    );

    // State and every output are registered; reset clears all at once.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            Grant  <= '0;
            Select <= '0;
            Valid  <= 1'b0;
            Busy   <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            cnt    <= cnt_n;
            Grant  <= grant_n;
            Select <= sel_n;
            Valid  <= valid_n;
            Busy   <= busy_n;
        end
    end

    // Next-state: arbitrate in IDLE, count down the burst, then idle a turn.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        grant_n = Grant;
        sel_n   = Select;
        valid_n = Valid;
        busy_n  = Busy;
        unique case (state)
            IDLE: begin
                if (any) begin
                    grant_n = {{(N_REQ-1){1'b0}}, 1'b1} << win;
                    sel_n   = win;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    cnt_n   = CNT_W'(BURST - 1);
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (!Req[Select] || cnt == '0) begin
                    grant_n = '0;
                    valid_n = 1'b0;
                    ptr_n   = next_idx(Select);
                    state_n = TURN;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            TURN: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter, BURST=4 and BURST=1 side by side,
// against a transaction-level bus-ownership model.
module tb_mux_rr_arbiter;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic [7:0] Req;
    logic [7:0] g4, g1;
    logic [2:0] s4, s1;
    logic       v4, v1, b4, b1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clock = ~Clock;

    mux_rr_arbiter #(.BURST(4)) u_dut4 (
        .Clock (Clock), .Resetn (Resetn), .Req (Req),
        .Grant (g4), .Select (s4), .Valid (v4), .Busy (b4)
    );

    mux_rr_arbiter #(.BURST(1)) u_dut1 (
        .Clock (Clock), .Resetn (Resetn), .Req (Req),
        .Grant (g1), .Select (s1), .Valid (v1), .Busy (b1)
    );

    typedef struct packed {
        logic [7:0] g;
        logic [2:0] s;
        logic       v;
        logic       b;
    } obs_t;

    obs_t q4[$];
    obs_t q1[$];

    // Model: who owns the bus, cycles held, turnaround pending, next start.
    int owner[2];
    int used[2];
    int cool[2];
    int ptr[2];
    int sel[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            owner[d] = -1;
            used[d]  = 0;
            cool[d]  = 0;
            ptr[d]   = 0;
            sel[d]   = 0;
        end
    endtask

    task automatic model_step(input int d, input logic [7:0] r);
        int lim;
        int i;
        lim = (d == 0) ? 4 : 1;
        if (owner[d] >= 0) begin
            if (!r[owner[d]] || used[d] == lim) begin
                owner[d] = -1;
                ptr[d]   = (sel[d] + 1) % 8;
                cool[d]  = 1;
            end else begin
                used[d]++;
            end
        end else if (cool[d] != 0) begin
            cool[d] = 0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                i = (ptr[d] + k) % 8;
                if (r[i] && owner[d] < 0) begin
                    owner[d] = i;
                    used[d]  = 1;
                    sel[d]   = i;
                end
            end
        end
    endtask

    function automatic obs_t model_obs(input int d);
        obs_t o;
        logic [7:0] one;
        one = 8'h01;
        o.g = (owner[d] >= 0) ? (one << owner[d]) : 8'h00;
        o.s = 3'(sel[d]);
        o.v = (owner[d] >= 0);
        o.b = (owner[d] >= 0) || (cool[d] != 0);
        return o;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic check_reset();
        chk("rst_g4", g4, 0);
        chk("rst_s4", s4, 0);
        chk("rst_v4", v4, 0);
        chk("rst_b4", b4, 0);
        chk("rst_g1", g1, 0);
        chk("rst_s1", s1, 0);
        chk("rst_v1", v1, 0);
        chk("rst_b1", b1, 0);
    endtask

    // Drive at a falling edge, predict the next rising edge, advance.
    task automatic cycle(input logic [7:0] r);
        Req = r;
        model_step(0, r);
        model_step(1, r);
        q4.push_back(model_obs(0));
        q1.push_back(model_obs(1));
        @(negedge Clock);
    endtask

    // Monitor: after each rising edge, compare against the oldest prediction.
    initial begin
        obs_t e4, e1;
        forever begin
            @(posedge Clock);
            #1;
            if (q4.size() > 0 && q1.size() > 0) begin
                e4 = q4.pop_front();
                e1 = q1.pop_front();
                chk("grant_b4", g4, e4.g);
                chk("select_b4", s4, e4.s);
                chk("valid_b4", v4, e4.v);
                chk("busy_b4", b4, e4.b);
                chk("grant_b1", g1, e1.g);
                chk("select_b1", s1, e1.s);
                chk("valid_b1", v1, e1.v);
                chk("busy_b1", b1, e1.b);
            end
        end
    end

    initial begin
        logic [7:0] cur;
        Resetn = 1'b0;
        Req    = 8'h00;
        model_reset();
        repeat (2) @(negedge Clock);
        check_reset();
        Resetn = 1'b1;

        repeat (20) cycle(8'h04);
        repeat (3) cycle(8'h00);
        repeat (70) cycle(8'hFF);
        repeat (3) cycle(8'h00);
        repeat (20) cycle(8'h81);
        repeat (3) cycle(8'h00);
        repeat (3) cycle(8'h08);
        repeat (4) cycle(8'h00);

        repeat (3) cycle(8'h20);
        Resetn = 1'b0;
        #1;
        check_reset();
        model_reset();
        @(negedge Clock);
        @(negedge Clock);
        Resetn = 1'b1;
        repeat (6) cycle(8'h20);
        repeat (3) cycle(8'h00);

        cur = 8'h00;
        for (int n = 0; n < 1500; n++) begin
            for (int b = 0; b < 8; b++) begin
                if (cur[b]) begin
                    if ($urandom_range(7) == 0) cur[b] = 1'b0;
                end else begin
                    if ($urandom_range(5) == 0) cur[b] = 1'b1;
                end
            end
            cycle(cur);
        end
        repeat (4) cycle(8'h00);

        @(posedge Clock);
        #2;
        chk("drain", q4.size() + q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
